seqdet_prog: RTL and testbench
==============================

# seqdet_prog

Runtime-programmable serial bit-sequence detector with a Moore-type output. It generalises the fixed 3-bit "101" detector to any pattern of 1..PAT_W bits. It adds a selectable overlap mode, a valid qualifier on the input stream and a saturating match counter. It sits on a single-bit serial input path; configuration is loaded by the local controller.

## Interface
Parameters:
- PAT_W, 8: maximum pattern length in bits (≥2)
- LEN_W, $clog2(PAT_W+1): width of the length field
- CNT_W, 8: match counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cfg_load  in  1  synchronous load of pattern/length/mode; clears history
- cfg_pattern  in  PAT_W  pattern; bit [len-1] is the first bit received, bit [0] the last
- cfg_len  in  LEN_W  pattern length
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = history cleared after each match
- x  in  1  serial data bit
- x_valid  in  1  x sampled only when high
- cnt_clr  in  1  synchronous clear of match_cnt
- match  out  1  Moore output, high while FSM is in HIT
- match_cnt  out  CNT_W  number of matches since reset, load or clear; saturating

## Operation
- FSM states: UNCFG, HUNT, HIT. Reset state is UNCFG.
- UNCFG: x is ignored. cfg_load moves the FSM to HUNT.
- cfg_load (any state): latch pattern, length and overlap; clear history, fill count and match_cnt; next state HUNT. x_valid in the same cycle is ignored.
- Length clamp: cfg_len=0 is treated as 1; cfg_len>PAT_W is treated as PAT_W.
- History: on x_valid, hist <= {hist[PAT_W-2:0], x}. fill increments and saturates at len.
- Hit condition: x_valid && fill_next ≥ len && low len bits of hist_next == low len bits of pattern.
- HUNT → HIT on a hit, else stay in HUNT.
- HIT → HIT on a hit at the next sampled bit. HIT → HUNT otherwise, including when x_valid is low. match is therefore one cycle per completing bit.
- cfg_overlap=0: on a hit, fill is forced to 0. The next match needs len fresh bits.
- match_cnt: +1 on each hit, saturating at 2^CNT_W-1.
- cnt_clr with a simultaneous hit gives match_cnt=1. cnt_clr alone gives 0.
- Reset values: match=0, match_cnt=0, hist=0, fill=0, config registers=0, state=UNCFG.

## Timing
- Latency: the completing bit is sampled at edge N; match and the incremented match_cnt are visible after edge N and hold until edge N+1.
- match is a pure decode of the state register; it has no combinational path from x.
- cfg_load takes effect at the next edge. The first usable bit is sampled at the edge after that.
- rst assertion mid-stream immediately forces all outputs to reset values. After release, the block stays in UNCFG until cfg_load.

## Configuration
- SEQDET_CNT_EN defined: match_cnt register and cnt_clr logic are present, as described above.
- SEQDET_CNT_EN undefined: no counter is built; match_cnt is tied to 0 and cnt_clr is ignored. match behaviour is unchanged.

## Structure
- Package seqdet_pkg holds the state enum (UNCFG, HUNT, HIT as 2-bit encoding) and a length-clamp function.
- Sub-module seqdet_hist holds the history shift register, fill counter and masked compare. It outputs a hit flag to the FSM in the top level.

## Test plan
- Pattern 101, len 3, overlap 1, stream 1,0,1,0,1 (all valid) → match high after bits 3 and 5; match_cnt=2.
- Same stream with overlap 0 → match only after bit 3; match_cnt=1.
- Pattern 1, len 1, overlap 0, stream 1,1,1 → match high 3 consecutive cycles; match_cnt=3. Then x=0 → match low.
- Pattern 101 with x_valid low for 2 cycles between each bit → match after the third valid bit only. It is high for 1 cycle and drops while x_valid is low.
- Reset mid-pattern after 1,0: match=0 and match_cnt=0 immediately. After release, bit 1 without cfg_load → no match (UNCFG).
- CNT_W=2, pattern 1, len 1, 5 ones → match_cnt saturates at 3. cnt_clr with a hit → 1. With SEQDET_CNT_EN undefined → match_cnt always 0.

Source files
------------

// File: rtl/seqdet_pkg.sv
// ---------------------------------------------------------------------------
// seqdet_pkg
// Shared types and helpers for the programmable sequence detector.
//   state_t   : detector FSM state (UNCFG / HUNT / HIT), 2-bit encoding
//   clamp_len : maps a requested pattern length onto the legal range 1..max
// ---------------------------------------------------------------------------
package seqdet_pkg;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        HUNT  = 2'd1,
        HIT   = 2'd2
    } state_t;

    // A zero length would make every bit a match; anything above the
    // hardware width cannot be stored, so both ends are pinned.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        if (len == 0)
            return 1;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/seqdet_hist.sv
// ---------------------------------------------------------------------------
// seqdet_hist
// Pattern configuration registers, serial history shift register, fill
// counter and masked pattern compare. Produces a combinational hit flag for
// the FSM in the top level.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   en            : detector configured (FSM not in UNCFG); gates sampling
//   cfg_load      : latch pattern/length/overlap, clear history and fill
//   cfg_pattern   : pattern, bit [len-1] first received, bit [0] last
//   cfg_len       : requested pattern length (clamped to 1..PAT_W)
//   cfg_overlap   : 1 = overlapping matches, 0 = restart after each match
//   x, x_valid    : serial data bit and its qualifier
//   hit           : the bit sampled at this edge completes a match
// ---------------------------------------------------------------------------
module seqdet_hist
    import seqdet_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             x,
    input  logic             x_valid,
    output logic             hit
);

    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic [PAT_W-1:0] hist_q;
    logic [LEN_W-1:0] fill_q;

    logic [PAT_W-1:0] hist_next;
    logic [LEN_W-1:0] fill_next;
    logic [PAT_W-1:0] mask;
    logic             sample;

    // A load cycle takes priority over data: x_valid is ignored then.
    assign sample = en && x_valid && !cfg_load;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through it can leave a value held and infer a latch.
        mask      = '0;
        hist_next = {hist_q[PAT_W-2:0], x};
        fill_next = (fill_q < len_q) ? fill_q + LEN_W'(1) : fill_q;
        for (int i = 0; i < PAT_W; i++)
            mask[i] = (LEN_W'(i) < len_q);
        // fill counts bits accepted since load or since the last
        // non-overlapping match; the compare is only trusted once it
        // covers the full pattern.
        hit = sample && (fill_next >= len_q) &&
              ((hist_next & mask) == (pat_q & mask));
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q  <= '0;
            len_q  <= '0;
            ovl_q  <= 1'b0;
            hist_q <= '0;
            fill_q <= '0;
        end else if (cfg_load) begin
            pat_q  <= cfg_pattern;
            len_q  <= LEN_W'(clamp_len(32'(cfg_len), PAT_W));
            ovl_q  <= cfg_overlap;
            hist_q <= '0;
            fill_q <= '0;
        end else if (sample) begin
            hist_q <= hist_next;
            // Non-overlapping mode: the matched bits may not be reused.
            fill_q <= (hit && !ovl_q) ? '0 : fill_next;
        end
    end

endmodule

// File: rtl/seqdet_prog.sv
// ---------------------------------------------------------------------------
// seqdet_prog
// Runtime-programmable serial bit-sequence detector, Moore output.
// Optional feature macro: SEQDET_CNT_EN -- when defined, a saturating match
// counter (match_cnt) with synchronous clear (cnt_clr) is built; when
// undefined, match_cnt is tied to zero and cnt_clr is ignored.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   cfg_load      : load pattern/length/overlap, clear history and counter
//   cfg_pattern   : pattern, bit [len-1] first received
//   cfg_len       : pattern length, 0 -> 1, >PAT_W -> PAT_W
//   cfg_overlap   : overlapping matches allowed when high
//   x, x_valid    : serial data bit and qualifier
//   cnt_clr       : synchronous clear of match_cnt
//   match         : high while the FSM is in HIT
//   match_cnt     : saturating count of matches
// ---------------------------------------------------------------------------
module seqdet_prog
    import seqdet_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             x,
    input  logic             x_valid,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt
);

    state_t state;
    logic   hit;

    seqdet_hist #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_hist (
        .clk         (clk),
        .rst         (rst),
        .en          (state != UNCFG),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .x           (x),
        .x_valid     (x_valid),
        .hit         (hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= UNCFG;
        end else if (cfg_load) begin
            state <= HUNT;
        end else begin
            case (state)
                UNCFG:     state <= UNCFG;
                HUNT, HIT: state <= hit ? HIT : HUNT;
                default:   state <= UNCFG;
            endcase
        end
    end

    // Moore output: decoded from the state register only.
    assign match = (state == HIT);

`ifdef SEQDET_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (cfg_load) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            // A hit coinciding with the clear is counted as the first match.
            cnt_q <= hit ? CNT_W'(1) : '0;
        end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign match_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seqdet_prog.sv
// ---------------------------------------------------------------------------
// tb_seqdet_prog
// Self-checking bench for seqdet_prog. Two instances share all inputs: one
// with the default 8-bit counter and one with a 2-bit counter so counter
// saturation is exercised. A queue-based model of the last len accepted bits
// predicts match and match_cnt each cycle; directed sequences add literal
// expectations, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_seqdet_prog;

    localparam int PAT_W = 8;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             x;
    logic             x_valid;
    logic             cnt_clr;
    logic             match, match2;
    logic [7:0]       match_cnt;
    logic [1:0]       match_cnt2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seqdet_prog #(.PAT_W(PAT_W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .x(x), .x_valid(x_valid),
        .cnt_clr(cnt_clr), .match(match), .match_cnt(match_cnt)
    );

    seqdet_prog #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .x(x), .x_valid(x_valid),
        .cnt_clr(cnt_clr), .match(match2), .match_cnt(match_cnt2)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Counter expectations collapse to zero when the counter is not built.
    function automatic int exp_cnt(input int v);
`ifdef SEQDET_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // ---------------- behavioural model ----------------
    bit         m_cfg;
    bit [7:0]   m_pat;
    int         m_len;
    bit         m_ovl;
    bit         mq[$];     // accepted bits, oldest first, at most m_len
    int         m_cnt8, m_cnt2;
    bit         m_match;

    task automatic model_step();
        bit h;
        if (!rst) begin
            m_cfg = 0; m_pat = 0; m_len = 0; m_ovl = 0; mq.delete();
            m_cnt8 = 0; m_cnt2 = 0; m_match = 0;
        end else if (cfg_load) begin
            m_cfg = 1;
            m_pat = cfg_pattern;
            m_len = int'(cfg_len);
            if (m_len == 0) m_len = 1;
            if (m_len > PAT_W) m_len = PAT_W;
            m_ovl = cfg_overlap;
            mq.delete();
            m_cnt8 = 0; m_cnt2 = 0; m_match = 0;
        end else begin
            h = 0;
            if (m_cfg && x_valid) begin
                mq.push_back(x);
                if (mq.size() > m_len) void'(mq.pop_front());
                if (mq.size() == m_len) begin
                    h = 1;
                    for (int i = 0; i < m_len; i++)
                        if (mq[i] != m_pat[m_len-1-i]) h = 0;
                end
                if (h && !m_ovl) mq.delete();
            end
            m_match = h;
            if (cnt_clr) begin
                m_cnt8 = h ? 1 : 0;
                m_cnt2 = h ? 1 : 0;
            end else if (h) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3)   m_cnt2++;
            end
        end
    endtask

    // Compare process: model advances on each edge, outputs sampled 1 later.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("match",  match,      m_match);
            check("cnt",    match_cnt,  exp_cnt(m_cnt8));
            check("match2", match2,     m_match);
            check("cnt2",   match_cnt2, exp_cnt(m_cnt2));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic b, input logic v);
        x = b; x_valid = v;
        @(negedge clk);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        cfg_load = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        x_valid = 1'b1; x = 1'b1;  // must be ignored during load
        @(negedge clk);
        cfg_load = 1'b0; x_valid = 1'b0;
    endtask

    task automatic run_bits(input logic [7:0] bits, input int n,
                            input logic [7:0] exp_m, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(bits[n-1-i], 1'b1);
            check(tag, match, exp_m[n-1-i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; x = 1'b0; x_valid = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_match", match, 0);
        check("rst_cnt", match_cnt, 0);
        rst = 1'b1;

        // UNCFG ignores data
        run_bits(8'b101, 3, 8'b000, "uncfg_match");

        // 101 overlapping
        load(8'b101, 4'd3, 1'b1);
        run_bits(8'b10101, 5, 8'b00101, "ovl_match");
        check("ovl_cnt", match_cnt, exp_cnt(2));

        // 101 non-overlapping
        load(8'b101, 4'd3, 1'b0);
        run_bits(8'b10101, 5, 8'b00100, "novl_match");
        check("novl_cnt", match_cnt, exp_cnt(1));

        // single-bit pattern, counter saturation in the 2-bit instance
        load(8'b1, 4'd1, 1'b0);
        run_bits(8'b111, 3, 8'b111, "len1_match");
        check("len1_cnt", match_cnt, exp_cnt(3));
        run_bits(8'b11, 2, 8'b11, "len1_more");
        check("len1_cnt5", match_cnt, exp_cnt(5));
        check("sat_cnt2", match_cnt2, exp_cnt(3));
        drive(1'b0, 1'b1);
        check("len1_drop", match, 0);
        cnt_clr = 1'b1;
        drive(1'b1, 1'b1);
        check("clr_hit_cnt", match_cnt, exp_cnt(1));
        check("clr_hit_match", match, 1);
        drive(1'b0, 1'b0);
        check("clr_cnt", match_cnt, exp_cnt(0));
        cnt_clr = 1'b0;

        // gaps in x_valid
        load(8'b101, 4'd3, 1'b1);
        drive(1'b1, 1'b1); check("gap_b1", match, 0);
        drive(1'b0, 1'b0); drive(1'b1, 1'b0);
        drive(1'b0, 1'b1); check("gap_b2", match, 0);
        drive(1'b1, 1'b0); drive(1'b0, 1'b0);
        drive(1'b1, 1'b1); check("gap_hit", match, 1);
        drive(1'b1, 1'b0); check("gap_drop", match, 0);

        // length clamps: 0 -> 1, 15 -> 8
        load(8'b1, 4'd0, 1'b1);
        run_bits(8'b01, 2, 8'b01, "len0_match");
        load(8'hA5, 4'd15, 1'b1);
        run_bits(8'hA5, 8, 8'h01, "len15_match");

        // asynchronous reset mid-stream
        load(8'b101, 4'd3, 1'b1);
        run_bits(8'b101, 3, 8'b001, "pre_rst");
        #2 rst = 1'b0;
        #1;
        check("async_match", match, 0);
        check("async_cnt", match_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        run_bits(8'b101, 3, 8'b000, "post_rst");

        // randomized traffic
        load(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 499) != 0);
            cfg_load    = ($urandom_range(0, 63) == 0);
            cfg_pattern = 8'($urandom);
            cfg_len     = 4'($urandom_range(0, 15));
            cfg_overlap = 1'($urandom);
            x           = 1'($urandom);
            x_valid     = ($urandom_range(0, 3) != 0);
            cnt_clr     = ($urandom_range(0, 49) == 0);
            @(negedge clk);
        end
        rst = 1'b1; cfg_load = 1'b0; x_valid = 1'b0; cnt_clr = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
